// File: rtl/key_event_decoder.sv
// Turns a debounced active-low key level into registered press, release,
// long-press and auto-repeat pulses, a held level and a wrapping press count.
module key_event_decoder #(
    parameter int LONG_CYCLES   = 16,
    parameter int REPEAT_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       key_n_i,
    output logic       press_o,
    output logic       release_o,
    output logic       long_press_o,
    output logic       repeat_o,
    output logic       held_o,
    output logic [7:0] press_count_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        LONG    = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] LONG_C   = CNT_W'(LONG_CYCLES);
    localparam logic [CNT_W-1:0] REPEAT_C = CNT_W'(REPEAT_CYCLES);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             long_q, long_d;
    logic             repeat_q, repeat_d;
    logic             held_q, held_d;
    logic [7:0]       count_q, count_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
        repeat_d  = 1'b0;
        count_d   = count_q;
        unique case (state_q)
            IDLE: begin
                if (!key_n_i) begin
                    state_d = PRESSED;
                    cnt_d   = ONE;
                    press_d = 1'b1;
                    count_d = count_q + 8'd1;
                end
            end
            PRESSED: begin
                // A high sample always releases, even on the long-press edge.
                if (key_n_i) begin
                    state_d   = IDLE;
                    release_d = 1'b1;
                end else if (cnt_q == LONG_C) begin
                    state_d = LONG;
                    long_d  = 1'b1;
                    cnt_d   = ONE;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            LONG: begin
                if (key_n_i) begin
                    state_d   = IDLE;
                    release_d = 1'b1;
                end else if (cnt_q == REPEAT_C) begin
                    repeat_d = 1'b1;
                    cnt_d    = ONE;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        held_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
            held_q    <= 1'b0;
            count_q   <= 8'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            repeat_q  <= repeat_d;
            held_q    <= held_d;
            count_q   <= count_d;
        end
    end

    assign press_o       = press_q;
    assign release_o     = release_q;
    assign long_press_o  = long_q;
    assign repeat_o      = repeat_q;
    assign held_o        = held_q;
    assign press_count_o = count_q;

endmodule

// File: tb/tb_key_event_decoder.sv
// Directed bench for key_event_decoder (LONG_CYCLES=16, REPEAT_CYCLES=4).
module tb_key_event_decoder;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       key_n = 1'b1;
    logic       press, rel, long_press, rpt, held;
    logic [7:0] press_count;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] exp_count = 8'd0;

    // Event vector {press, release, long_press, repeat, held}.
    localparam logic [4:0] EV_Z  = 5'b00000;
    localparam logic [4:0] EV_P  = 5'b10001;
    localparam logic [4:0] EV_R  = 5'b01000;
    localparam logic [4:0] EV_L  = 5'b00101;
    localparam logic [4:0] EV_RP = 5'b00011;
    localparam logic [4:0] EV_H  = 5'b00001;

    logic [4:0] ev;
    assign ev = {press, rel, long_press, rpt, held};

    key_event_decoder #(.LONG_CYCLES(16), .REPEAT_CYCLES(4), .CNT_W(8)) dut (
        .clk_i(clk), .reset_i(reset), .key_n_i(key_n),
        .press_o(press), .release_o(rel), .long_press_o(long_press),
        .repeat_o(rpt), .held_o(held), .press_count_o(press_count)
    );

    always #5 clk = ~clk;

    // Drive one sample, let the edge take it, and settle past the edge.
    task automatic step(input logic k);
        key_n = k;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b0);
            n_cmp++;
            if (ev !== EV_Z || press_count !== 8'd0) begin
                n_err++;
                $display("FAIL reset_hold[%0d]: events=%b count=%0d, want events=%b count=0", i, ev, press_count, EV_Z);
            end
        end
        reset = 1'b0;
        exp_count = 8'd0;
        step(1'b0);
        exp_count++;
        n_cmp++;
        if (ev !== EV_P || press_count !== exp_count) begin
            n_err++;
            $display("FAIL reset_first_press: events=%b count=%0d, want %b/%0d", ev, press_count, EV_P, exp_count);
        end
        step(1'b1);
        n_cmp++;
        if (ev !== EV_R) begin
            n_err++;
            $display("FAIL reset_release: events=%b, want %b", ev, EV_R);
        end
        step(1'b1);
    endtask

    task automatic test_short_press();
        logic [4:0] exp;
        for (int i = 0; i < 7; i++) begin
            step(i < 5 ? 1'b0 : 1'b1);
            if (i == 0) begin
                exp = EV_P;
                exp_count++;
            end else if (i < 5) exp = EV_H;
            else if (i == 5) exp = EV_R;
            else exp = EV_Z;
            n_cmp++;
            if (ev !== exp || press_count !== exp_count) begin
                n_err++;
                $display("FAIL short_press[T+%0d]: events=%b count=%0d, want %b/%0d", i + 1, ev, press_count, exp, exp_count);
            end
        end
    endtask

    task automatic test_long_hold();
        logic [4:0] exp;
        for (int i = 0; i < 32; i++) begin
            step(i < 30 ? 1'b0 : 1'b1);
            if (i == 0) begin
                exp = EV_P;
                exp_count++;
            end else if (i == 16) exp = EV_L;
            else if (i == 20 || i == 24 || i == 28) exp = EV_RP;
            else if (i < 30) exp = EV_H;
            else if (i == 30) exp = EV_R;
            else exp = EV_Z;
            n_cmp++;
            if (ev !== exp || press_count !== exp_count) begin
                n_err++;
                $display("FAIL long_hold[T+%0d]: events=%b count=%0d, want %b/%0d", i + 1, ev, press_count, exp, exp_count);
            end
        end
    endtask

    task automatic test_long_boundary();
        logic [4:0] exp;
        for (int lows = 16; lows <= 17; lows++) begin
            for (int i = 0; i <= lows; i++) begin
                step(i < lows ? 1'b0 : 1'b1);
                if (i == 0) begin
                    exp = EV_P;
                    exp_count++;
                end else if (i == lows) exp = EV_R;
                else if (i == 16) exp = EV_L;
                else exp = EV_H;
                n_cmp++;
                if (ev !== exp || press_count !== exp_count) begin
                    n_err++;
                    $display("FAIL long_boundary_%0d[T+%0d]: events=%b count=%0d, want %b/%0d", lows, i + 1, ev, press_count, exp, exp_count);
                end
            end
            step(1'b1);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] start;
        logic [4:0] exp;
        start = press_count;
        for (int i = 0; i < 4; i++) begin
            step(i[0]);
            exp = i[0] ? EV_R : EV_P;
            n_cmp++;
            if (ev !== exp) begin
                n_err++;
                $display("FAIL back_to_back[%0d]: events=%b, want %b", i, ev, exp);
            end
        end
        exp_count = exp_count + 8'd2;
        n_cmp++;
        if (press_count !== exp_count || press_count - start !== 8'd2) begin
            n_err++;
            $display("FAIL back_to_back_count: count=%0d, want %0d", press_count, exp_count);
        end
    endtask

    task automatic test_wrap_and_reset_mid_hold();
        reset = 1'b1;
        step(1'b1);
        reset = 1'b0;
        for (int i = 1; i <= 256; i++) begin
            step(1'b0);
            step(1'b1);
            if (i == 255 || i == 256) begin
                n_cmp++;
                if (press_count !== 8'(i)) begin
                    n_err++;
                    $display("FAIL wrap_count[%0d]: count=%0d, want %0d", i, press_count, 8'(i));
                end
            end
        end
        for (int i = 0; i < 20; i++) step(1'b0);
        n_cmp++;
        if (ev !== EV_H || press_count !== 8'd1) begin
            n_err++;
            $display("FAIL pre_reset_hold: events=%b count=%0d, want %b/1", ev, press_count, EV_H);
        end
        reset = 1'b1;
        step(1'b0);
        n_cmp++;
        if (ev !== EV_Z || press_count !== 8'd0) begin
            n_err++;
            $display("FAIL reset_mid_hold: events=%b count=%0d, want 00000/0", ev, press_count);
        end
        reset = 1'b0;
        step(1'b1);
        n_cmp++;
        if (ev !== EV_Z || press_count !== 8'd0) begin
            n_err++;
            $display("FAIL no_release_after_reset: events=%b count=%0d, want 00000/0", ev, press_count);
        end
    endtask

    initial begin
        test_reset();
        test_short_press();
        test_long_hold();
        test_long_boundary();
        test_back_to_back();
        test_wrap_and_reset_mid_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
